// File: rtl/fifo_frame_packetizer.sv
// Drains the sample FIFO into framed packets on a 32-bit valid/ready stream:
// header {MAGIC, seq}, length, payload words, XOR checksum (tlast).
module fifo_frame_packetizer #(
  parameter int          FIFO_PTR_WIDTH = 10,
  parameter int          FRAME_LEN      = 64,
  parameter logic [15:0] MAGIC          = 16'hA55A,
  // Reset value of the sequence counter; left at zero outside bring-up benches.
  parameter logic [15:0] SEQ_INIT       = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic                      flush,
  input  logic [31:0]               fifo_data,
  input  logic                      fifo_rdy,
  input  logic [FIFO_PTR_WIDTH-1:0] fifo_level,
  output logic                      fifo_pop,
  output logic [31:0]               m_tdata,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [15:0]               seq_num,
  output logic                      busy,
  output logic                      err_starve
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LEN,
    S_PAYLOAD,
    S_CSUM
  } state_e;

  localparam logic [FIFO_PTR_WIDTH-1:0] FRAME_LEN_LVL = FIFO_PTR_WIDTH'(FRAME_LEN);
  localparam logic [15:0]               FRAME_LEN_16  = 16'(FRAME_LEN);

  state_e      state_q;
  logic [15:0] seq_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [31:0] csum_q;
  logic        flush_pend_q;
  logic        err_q;

  logic        full_ok;
  logic        part_ok;
  logic        start;
  logic        accept;
  logic [15:0] len_d;

  // A full frame always wins over a pending flush.
  assign full_ok = en && (fifo_level >= FRAME_LEN_LVL);
  assign part_ok = en && flush_pend_q && (fifo_level != '0);
  assign start   = (state_q == S_IDLE) && (full_ok || part_ok);
  assign len_d   = full_ok ? FRAME_LEN_16 : 16'(fifo_level);

  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    unique case (state_q)
      S_HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = {MAGIC, seq_q};
      end
      S_LEN: begin
        m_tvalid = 1'b1;
        m_tdata  = {16'h0000, len_q};
      end
      S_PAYLOAD: begin
        m_tvalid = fifo_rdy;
        m_tdata  = fifo_data;
      end
      S_CSUM: begin
        m_tvalid = 1'b1;
        m_tdata  = csum_q;
      end
      default: begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
      end
    endcase
  end

  assign accept     = m_tvalid && m_tready;
  assign fifo_pop   = (state_q == S_PAYLOAD) && accept;
  assign m_tlast    = (state_q == S_CSUM);
  assign busy       = (state_q != S_IDLE);
  assign seq_num    = seq_q;
  assign err_starve = err_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      seq_q        <= SEQ_INIT;
      len_q        <= '0;
      cnt_q        <= '0;
      csum_q       <= '0;
      flush_pend_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (start) begin
        flush_pend_q <= 1'b0;
      end else if (flush) begin
        flush_pend_q <= 1'b1;
      end else if ((state_q == S_IDLE) && (fifo_level == '0)) begin
        flush_pend_q <= 1'b0;
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q   <= len_d;
            csum_q  <= '0;
            state_q <= S_HDR;
          end
        end
        S_HDR: begin
          if (accept) state_q <= S_LEN;
        end
        S_LEN: begin
          if (accept) begin
            cnt_q   <= len_q;
            state_q <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!fifo_rdy) err_q <= 1'b1;
          if (accept) begin
            csum_q <= csum_q ^ fifo_data;
            cnt_q  <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_q <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (accept) begin
            seq_q   <= seq_q + 16'd1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_packetizer.sv
// Bench for fifo_frame_packetizer: behavioural FIFO, stream scoreboard,
// table of frame vectors and hand-written corner sequences.
module tb_fifo_frame_packetizer;

  localparam int          PW    = 10;
  localparam int          FL    = 4;
  localparam logic [15:0] MAGIC = 16'hA55A;
  localparam logic [15:0] SEQ0  = 16'hFFFE;

  logic          clk = 1'b0;
  logic          rstn, en, flush, m_tready;
  logic          fifo_pop, fifo_rdy, m_tvalid, m_tlast, busy, err_starve;
  logic [31:0]   fifo_data, m_tdata;
  logic [PW-1:0] fifo_level;
  logic [15:0]   seq_num;

  always #5 clk = ~clk;

  fifo_frame_packetizer #(
    .FIFO_PTR_WIDTH(PW),
    .FRAME_LEN     (FL),
    .MAGIC         (MAGIC),
    .SEQ_INIT      (SEQ0)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .flush     (flush),
    .fifo_data (fifo_data),
    .fifo_rdy  (fifo_rdy),
    .fifo_level(fifo_level),
    .fifo_pop  (fifo_pop),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .seq_num   (seq_num),
    .busy      (busy),
    .err_starve(err_starve)
  );

  // Behavioural FIFO; "steal" models a second consumer removing the head word.
  logic [31:0] mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        steal  = 1'b0;

  always @(posedge clk) rd_ptr <= rd_ptr + int'(fifo_pop) + int'(steal);

  assign fifo_level = PW'(wr_ptr - rd_ptr);
  assign fifo_rdy   = (wr_ptr != rd_ptr);
  assign fifo_data  = mem[rd_ptr[7:0]];

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] seq_exp = SEQ0;
  logic [31:0] csum_m;

  task automatic exp_begin(input logic [15:0] len);
    exp_q.push_back({1'b0, MAGIC, seq_exp});
    exp_q.push_back({1'b0, 16'h0000, len});
    csum_m = '0;
  endtask

  task automatic exp_pay(input logic [31:0] w);
    exp_q.push_back({1'b0, w});
    csum_m = csum_m ^ w;
  endtask

  task automatic exp_end(input logic [31:0] cs);
    exp_q.push_back({1'b1, cs});
    seq_exp = seq_exp + 16'd1;
  endtask

  logic bp_mode = 1'b0;
  initial begin
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      m_tready = bp_mode ? ~m_tready : 1'b1;
    end
  end

  // Stream monitor: scoreboard, stall stability, pop accounting.
  int          pop_cnt    = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  beat_t       mon_e;

  always @(negedge clk) begin
    #1;
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 64'(m_tvalid), 64'(1'b1));
        check("stall_data_held", 64'(m_tdata), 64'(prev_data));
      end
      if (!m_tready) check("no_pop_when_stalled", 64'(fifo_pop), 64'(1'b0));
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got last=%0b data=%0h, expected no beat", m_tlast, m_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat", 64'({m_tlast, m_tdata}), 64'(mon_e));
        end
      end
      if (fifo_pop) pop_cnt++;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  task automatic wait_idle(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (exp_q.size() == 0 && !busy) passes++;
    else $display("FAIL frame_timeout: got %0d beats outstanding busy=%0b, expected 0 and 0",
                  exp_q.size(), busy);
  endtask

  typedef struct packed {
    logic [2:0]       n;
    logic             fl;
    logic             bp;
    logic [3:0][31:0] d;
    logic [15:0]      exp_len;
    logic [31:0]      exp_csum;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] n, input logic fl, input logic bp,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d,
                              input logic [15:0] len, input logic [31:0] cs);
    vec_t v;
    v.n        = n;
    v.fl       = fl;
    v.bp       = bp;
    v.d        = {d, c, b, a};
    v.exp_len  = len;
    v.exp_csum = cs;
    return v;
  endfunction

  vec_t tbl [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within 20000 cycles");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(3'd4, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4, 16'd4, 32'h0000_0004);
    tbl[1] = mk(3'd4, 1'b0, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 16'd4, 32'h0000_0004);
    tbl[2] = mk(3'd2, 1'b1, 1'b0, 32'd7, 32'd9, 32'd0, 32'd0, 16'd2, 32'h0000_000E);
    tbl[3] = mk(3'd4, 1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678, 32'h0F0F0F0F, 32'hFFFFFFFF,
                16'd4, 32'h3C691867);

    rstn = 1'b0; en = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_tvalid", 64'(m_tvalid), 64'(1'b0));
    check("rst_tlast", 64'(m_tlast), 64'(1'b0));
    check("rst_pop", 64'(fifo_pop), 64'(1'b0));
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_seq", 64'(seq_num), 64'(SEQ0));
    check("rst_err", 64'(err_starve), 64'(1'b0));
    @(negedge clk);
    rstn = 1'b1; en = 1'b1;

    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      bp_mode = tbl[r].bp;
      pop_cnt = 0;
      exp_begin(tbl[r].exp_len);
      for (int i = 0; i < int'(tbl[r].n); i++) exp_pay(tbl[r].d[i]);
      exp_end(tbl[r].exp_csum);
      for (int i = 0; i < int'(tbl[r].n); i++) push(tbl[r].d[i]);
      if (tbl[r].fl) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
      wait_idle(100);
      bp_mode = 1'b0;
      check("row_pops", 64'(pop_cnt), 64'(tbl[r].n));
      check("row_seq", 64'(seq_num), 64'(seq_exp));
    end

    // Flush with an empty FIFO must not leave a stale pending flush.
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("empty_flush_idle", 64'(busy), 64'(1'b0));
    push(32'd3); push(32'd5);
    repeat (6) @(negedge clk);
    #2;
    check("no_stale_flush", 64'(busy), 64'(1'b0));
    exp_begin(16'd2); exp_pay(32'd3); exp_pay(32'd5); exp_end(csum_m);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_idle(100);

    // Starvation: the head word is stolen as the frame starts.
    @(negedge clk);
    exp_begin(16'd4);
    exp_pay(32'd20); exp_pay(32'd30); exp_pay(32'd40); exp_pay(32'd50);
    exp_end(csum_m);
    push(32'd10); push(32'd20); push(32'd30); push(32'd40);
    steal = 1'b1;
    @(negedge clk);
    steal = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    check("starve_tvalid", 64'(m_tvalid), 64'(1'b0));
    check("starve_busy", 64'(busy), 64'(1'b1));
    check("starve_err", 64'(err_starve), 64'(1'b1));
    @(negedge clk);
    push(32'd50);
    wait_idle(100);
    check("starve_err_sticky", 64'(err_starve), 64'(1'b1));

    // Reset after two payload words have been accepted.
    @(negedge clk);
    pop_cnt = 0;
    push(32'd61); push(32'd62); push(32'd63); push(32'd64);
    exp_begin(16'd4); exp_pay(32'd61); exp_pay(32'd62);
    begin
      int n = 0;
      while (pop_cnt < 2 && n < 50) begin
        @(negedge clk);
        #2;
        n++;
      end
      check("reach_payload", 64'(pop_cnt), 64'(2));
    end
    @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'(1'b1));
    exp_q.delete();
    rstn = 1'b0; en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #2;
    check("mid_rst_tvalid", 64'(m_tvalid), 64'(1'b0));
    check("mid_rst_busy", 64'(busy), 64'(1'b0));
    check("mid_rst_seq", 64'(seq_num), 64'(SEQ0));
    check("mid_rst_err", 64'(err_starve), 64'(1'b0));
    check("mid_rst_tlast", 64'(m_tlast), 64'(1'b0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
